// File: rtl/multicore_ctrl_pkg.sv
// Shared types and register offsets for the worker-core run controller.
package multicore_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReset   = 3'd1,
    StRun     = 3'd2,
    StDone    = 3'd3,
    StTimeout = 3'd4
  } core_state_e;

  localparam logic [3:0] CtrlOffset      = 4'h0;
  localparam logic [3:0] BootAddrOffset  = 4'h4;
  localparam logic [3:0] StatusOffset    = 4'h8;
  localparam logic [3:0] TimeoutOffset   = 4'hC;
  localparam logic [8:0] IrqStatusOffset = 9'h100;
  localparam logic [8:0] IrqEnableOffset = 9'h104;

  localparam int unsigned IrqTimeoutBitOffset = 16;
  localparam int unsigned MaxCores            = 16;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TileLink-UL bundle types shared by crossbar devices.
// 32-bit data, 8-bit source id.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/multicore_ctrl_core_fsm.sv
// Run-state machine for one worker core: reset hold, watchdog, boot latch.
module multicore_ctrl_core_fsm
  import multicore_ctrl_pkg::*;
#(
  parameter int unsigned ResetCycles     = 8,
  parameter int unsigned TimeoutWidth    = 32,
  parameter logic [31:0] DefaultBootAddr = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        done_i,
  input  logic [31:0] boot_addr_i,
  input  logic [31:0] timeout_i,
  output core_state_e state_o,
  output logic        core_rst_o,
  output logic [31:0] boot_addr_o,
  output logic        done_set_o,
  output logic        timeout_set_o
);

  localparam int unsigned CntW = $clog2(ResetCycles + 1);

  core_state_e             state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [TimeoutWidth-1:0] wd_q, wd_d;
  logic [31:0]             boot_q, boot_d;
  logic                    wd_hit;

  assign wd_hit = (timeout_i != '0) &&
                  (32'(wd_q) == timeout_i - 32'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wd_q    <= '0;
      boot_q  <= DefaultBootAddr;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      boot_q  <= boot_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wd_d          = wd_q;
    boot_d        = boot_q;
    done_set_o    = 1'b0;
    timeout_set_o = 1'b0;
    unique case (state_q)
      StIdle, StDone, StTimeout: begin
        if (start_i && !abort_i) begin
          state_d = StReset;
          cnt_d   = CntW'(ResetCycles);
          boot_d  = boot_addr_i;
        end
      end
      StReset: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StRun;
            wd_d    = '0;
          end
        end
      end
      StRun: begin
        // abort beats done, done beats timeout
        if (abort_i) begin
          state_d = StIdle;
        end else if (done_i) begin
          state_d    = StDone;
          done_set_o = 1'b1;
        end else if (wd_hit) begin
          state_d       = StTimeout;
          timeout_set_o = 1'b1;
        end else if (!(&wd_q)) begin
          wd_d = wd_q + TimeoutWidth'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign state_o     = state_q;
  assign core_rst_o  = (state_q != StRun);
  assign boot_addr_o = boot_q;

endmodule

// File: rtl/multicore_ctrl.sv
// TL-UL run controller for the worker cores: register decode, IRQ, per-core FSMs.
module multicore_ctrl
  import multicore_ctrl_pkg::*;
#(
  parameter int unsigned NumCores        = 2,
  parameter int unsigned ResetCycles     = 8,
  parameter int unsigned TimeoutWidth    = 32,
  parameter logic [31:0] DefaultBootAddr = 32'h0
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_sys_i,
  input  tlul_pkg::tl_h2d_t        tl_i,
  output tlul_pkg::tl_d2h_t        tl_o,
  input  logic [NumCores-1:0]      core_done_i,
  output logic [NumCores-1:0]      core_rst_o,
  output logic [32*NumCores-1:0]   boot_addr_o,
  output logic                     irq_o
);

  localparam logic [15:0] CoreMask = 16'((32'd1 << NumCores) - 32'd1);
  localparam logic [31:0] IrqMask  = {CoreMask, CoreMask};

  logic [31:0] boot_q [NumCores];
  logic [31:0] tmo_q  [NumCores];
  core_state_e state  [NumCores];
  logic [31:0] irq_status_q, irq_status_d;
  logic [31:0] irq_enable_q;
  logic        irq_q;

  logic        rsp_valid_q;
  logic [2:0]  rsp_op_q;
  logic [1:0]  rsp_size_q;
  logic [7:0]  rsp_src_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;

  logic        acc, is_get, is_put, ok;
  logic [8:0]  off;
  logic [3:0]  core_idx, reg_sel;
  logic        core_hit, st_hit, en_hit;
  logic        err, wr_en;
  logic [31:0] rdata, core_rdata;
  logic [NumCores-1:0] start, abort, boot_wr, tmo_wr;
  logic [NumCores-1:0] done_set, tmo_set;
  logic [31:0] irq_set;
  logic        unused_tl;

  assign unused_tl = ^{tl_i.a_param, tl_i.a_mask, tl_i.a_address[31:9]};

  assign acc      = tl_i.a_valid & ~rsp_valid_q;
  assign is_get   = (tl_i.a_opcode == tlul_pkg::Get);
  assign is_put   = (tl_i.a_opcode == tlul_pkg::PutFullData);
  assign ok       = (is_get | is_put) & (tl_i.a_address[1:0] == 2'b00);
  assign off      = tl_i.a_address[8:0];
  assign core_idx = off[7:4];
  assign reg_sel  = off[3:0];
  assign core_hit = ~off[8] & (32'(core_idx) < NumCores);
  assign st_hit   = (off == IrqStatusOffset);
  assign en_hit   = (off == IrqEnableOffset);

  always_comb begin
    core_rdata = '0;
    for (int i = 0; i < NumCores; i++) begin
      if (core_idx == 4'(i)) begin
        case (reg_sel)
          BootAddrOffset: core_rdata = boot_q[i];
          StatusOffset:   core_rdata = 32'(state[i]);
          TimeoutOffset:  core_rdata = tmo_q[i];
          default:        core_rdata = '0;
        endcase
      end
    end
  end

  always_comb begin
    err   = 1'b0;
    rdata = '0;
    unique case (1'b1)
      !ok: err = 1'b1;
      ok && core_hit: begin
        err   = is_put && (reg_sel == StatusOffset);
        rdata = core_rdata;
      end
      ok && st_hit: rdata = irq_status_q;
      ok && en_hit: rdata = irq_enable_q;
      default: err = 1'b1;
    endcase
  end

  assign wr_en = acc & is_put & ~err;

  always_comb begin
    start   = '0;
    abort   = '0;
    boot_wr = '0;
    tmo_wr  = '0;
    for (int i = 0; i < NumCores; i++) begin
      if (wr_en && core_hit && core_idx == 4'(i)) begin
        start[i]   = (reg_sel == CtrlOffset) & tl_i.a_data[0];
        abort[i]   = (reg_sel == CtrlOffset) & tl_i.a_data[1];
        boot_wr[i] = (reg_sel == BootAddrOffset);
        tmo_wr[i]  = (reg_sel == TimeoutOffset);
      end
    end
  end

  assign irq_set = 32'(done_set) |
                   (32'(tmo_set) << IrqTimeoutBitOffset);

  // hardware set wins over a same-cycle W1C
  always_comb begin
    irq_status_d = irq_status_q;
    if (wr_en && st_hit) begin
      irq_status_d = irq_status_d & ~tl_i.a_data;
    end
    irq_status_d = (irq_status_d | irq_set) & IrqMask;
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      for (int i = 0; i < NumCores; i++) begin
        boot_q[i] <= DefaultBootAddr;
        tmo_q[i]  <= '0;
      end
      irq_status_q <= '0;
      irq_enable_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      for (int i = 0; i < NumCores; i++) begin
        if (boot_wr[i]) boot_q[i] <= tl_i.a_data;
        if (tmo_wr[i])  tmo_q[i]  <= tl_i.a_data;
      end
      irq_status_q <= irq_status_d;
      if (wr_en && en_hit) begin
        irq_enable_q <= tl_i.a_data & IrqMask;
      end
      irq_q <= |(irq_status_q & irq_enable_q);
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_size_q  <= '0;
      rsp_src_q   <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else if (acc) begin
      rsp_valid_q <= 1'b1;
      rsp_op_q    <= is_get ? tlul_pkg::AccessAckData
                            : tlul_pkg::AccessAck;
      rsp_size_q  <= tl_i.a_size;
      rsp_src_q   <= tl_i.a_source;
      rsp_data_q  <= (is_get && !err) ? rdata : '0;
      rsp_err_q   <= err;
    end else if (tl_i.d_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = rsp_valid_q;
    tl_o.d_opcode = rsp_op_q;
    tl_o.d_size   = rsp_size_q;
    tl_o.d_source = rsp_src_q;
    tl_o.d_data   = rsp_data_q;
    tl_o.d_error  = rsp_err_q;
    tl_o.a_ready  = ~rsp_valid_q;
  end

  assign irq_o = irq_q;

  for (genvar g = 0; g < NumCores; g++) begin : gen_core
    multicore_ctrl_core_fsm #(
      .ResetCycles    (ResetCycles),
      .TimeoutWidth   (TimeoutWidth),
      .DefaultBootAddr(DefaultBootAddr)
    ) u_fsm (
      .clk_i        (clk_sys_i),
      .rst_i        (rst_sys_i),
      .start_i      (start[g]),
      .abort_i      (abort[g]),
      .done_i       (core_done_i[g]),
      .boot_addr_i  (boot_q[g]),
      .timeout_i    (tmo_q[g]),
      .state_o      (state[g]),
      .core_rst_o   (core_rst_o[g]),
      .boot_addr_o  (boot_addr_o[32*g +: 32]),
      .done_set_o   (done_set[g]),
      .timeout_set_o(tmo_set[g])
    );
  end

endmodule

// File: tb/tb_multicore_ctrl.sv
// Directed bench for multicore_ctrl with two cores.
module tb_multicore_ctrl;

  localparam logic [31:0] DEF = 32'hA000_0000;
  localparam logic [2:0] OP_PUT  = 3'h0;
  localparam logic [2:0] OP_PART = 3'h1;
  localparam logic [2:0] OP_GET  = 3'h4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  tlul_pkg::tl_h2d_t tl_h2d;
  tlul_pkg::tl_d2h_t tl_d2h;
  logic [1:0]  core_done;
  logic [1:0]  core_rst;
  logic [63:0] boot_addr;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  multicore_ctrl #(
    .NumCores(2), .ResetCycles(8),
    .TimeoutWidth(32), .DefaultBootAddr(DEF)
  ) dut (
    .clk_sys_i  (clk),
    .rst_sys_i  (rst),
    .tl_i       (tl_h2d),
    .tl_o       (tl_d2h),
    .core_done_i(core_done),
    .core_rst_o (core_rst),
    .boot_addr_o(boot_addr),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic tl_xfer(input logic [2:0] op,
                         input logic [31:0] addr,
                         input logic [31:0] data,
                         input logic [1:0] done_pulse,
                         output logic [31:0] rdata,
                         output logic err);
    int n;
    @(negedge clk);
    tl_h2d.a_valid   = 1'b1;
    tl_h2d.a_opcode  = op;
    tl_h2d.a_size    = 2'd2;
    tl_h2d.a_source  = 8'h11;
    tl_h2d.a_address = addr;
    tl_h2d.a_mask    = 4'hF;
    tl_h2d.a_data    = data;
    tl_h2d.d_ready   = 1'b1;
    core_done        = done_pulse;
    n = 0;
    while (!tl_d2h.a_ready && n < 20) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    tl_h2d.a_valid = 1'b0;
    core_done      = 2'b00;
    n = 0;
    while (!tl_d2h.d_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (tl_d2h.d_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL tl_rsp_timeout addr=%h got d_valid=%b want 1",
               addr, tl_d2h.d_valid);
    end
    rdata = tl_d2h.d_data;
    err   = tl_d2h.d_error;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_cmp++;
    if (core_rst !== 2'b11) begin
      n_fail++; $display("FAIL rst_core_rst got %b want 11", core_rst);
    end
    n_cmp++;
    if (boot_addr !== {DEF, DEF}) begin
      n_fail++; $display("FAIL rst_boot got %h want %h", boot_addr, {DEF, DEF});
    end
    n_cmp++;
    if ({irq, tl_d2h.a_ready, tl_d2h.d_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL rst_hs got irq/a_ready/d_valid=%b want 010",
               {irq, tl_d2h.a_ready, tl_d2h.d_valid});
    end
    tl_xfer(OP_GET, 32'h008, 0, 2'b00, rd, er);
    n_cmp++;
    if ({er, rd} !== 33'h0) begin
      n_fail++; $display("FAIL rst_status0 got %h err %b want 0", rd, er);
    end
    tl_xfer(OP_GET, 32'h100, 0, 2'b00, rd, er);
    n_cmp++;
    if ({er, rd} !== 33'h0) begin
      n_fail++; $display("FAIL rst_irqst got %h err %b want 0", rd, er);
    end
  endtask

  task automatic test_bringup();
    logic [31:0] rd; logic er; int t0; int n;
    tl_xfer(OP_PUT, 32'h004, 32'h0010_0000, 2'b00, rd, er);
    tl_xfer(OP_PUT, 32'h000, 32'h1, 2'b00, rd, er);
    t0 = cyc - 1;
    tl_xfer(OP_GET, 32'h008, 0, 2'b00, rd, er);
    n_cmp++;
    if (rd !== 32'd1) begin
      n_fail++; $display("FAIL bring_status_reset got %0d want 1", rd);
    end
    n = 0;
    while (core_rst[0] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (cyc - t0 !== 8) begin
      n_fail++; $display("FAIL bring_rst_len got %0d want 8", cyc - t0);
    end
    tl_xfer(OP_GET, 32'h008, 0, 2'b00, rd, er);
    n_cmp++;
    if (rd !== 32'd2) begin
      n_fail++; $display("FAIL bring_status_run got %0d want 2", rd);
    end
    n_cmp++;
    if (boot_addr[31:0] !== 32'h0010_0000) begin
      n_fail++; $display("FAIL bring_boot got %h want 00100000", boot_addr[31:0]);
    end
  endtask

  task automatic test_done_irq();
    logic [31:0] rd; logic er;
    tl_xfer(OP_PUT, 32'h104, 32'h1, 2'b00, rd, er);
    @(negedge clk); core_done = 2'b01;
    @(posedge clk); #1; core_done = 2'b00;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL done_irq_early got %b want 0", irq);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({irq, core_rst[0]} !== 2'b11) begin
      n_fail++; $display("FAIL done_irq got irq/rst=%b want 11", {irq, core_rst[0]});
    end
    tl_xfer(OP_GET, 32'h008, 0, 2'b00, rd, er);
    n_cmp++;
    if (rd !== 32'd3) begin
      n_fail++; $display("FAIL done_status got %0d want 3", rd);
    end
    tl_xfer(OP_PUT, 32'h100, 32'h1, 2'b00, rd, er);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL done_w1c_irq got %b want 0", irq);
    end
    tl_xfer(OP_GET, 32'h100, 0, 2'b00, rd, er);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL done_w1c_st got %h want 0", rd);
    end
  endtask

  task automatic test_watchdog();
    logic [31:0] rd; logic er; int t_run; int n;
    tl_xfer(OP_PUT, 32'h01C, 32'd100, 2'b00, rd, er);
    tl_xfer(OP_PUT, 32'h010, 32'h1, 2'b00, rd, er);
    n = 0;
    while (core_rst[1] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    t_run = cyc;
    n = 0;
    while (!core_rst[1] && n < 300) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (cyc - t_run !== 100) begin
      n_fail++; $display("FAIL wd_len got %0d want 100", cyc - t_run);
    end
    tl_xfer(OP_GET, 32'h018, 0, 2'b00, rd, er);
    n_cmp++;
    if (rd !== 32'd4) begin
      n_fail++; $display("FAIL wd_status got %0d want 4", rd);
    end
    tl_xfer(OP_GET, 32'h100, 0, 2'b00, rd, er);
    n_cmp++;
    if (rd !== 32'h0002_0000) begin
      n_fail++; $display("FAIL wd_irqst got %h want 00020000", rd);
    end
    n_cmp++;
    if ({irq, core_rst[1]} !== 2'b01) begin
      n_fail++; $display("FAIL wd_pins got irq/rst=%b want 01", {irq, core_rst[1]});
    end
  endtask

  task automatic test_run_writes();
    logic [31:0] rd; logic er; int n;
    tl_xfer(OP_PUT, 32'h000, 32'h1, 2'b00, rd, er);
    n = 0;
    while (core_rst[0] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    tl_xfer(OP_PUT, 32'h004, 32'h2000_0000, 2'b00, rd, er);
    n_cmp++;
    if (boot_addr[31:0] !== 32'h0010_0000) begin
      n_fail++; $display("FAIL run_boot_pin got %h want 00100000", boot_addr[31:0]);
    end
    tl_xfer(OP_GET, 32'h004, 0, 2'b00, rd, er);
    n_cmp++;
    if (rd !== 32'h2000_0000) begin
      n_fail++; $display("FAIL run_boot_reg got %h want 20000000", rd);
    end
    tl_xfer(OP_PUT, 32'h000, 32'h1, 2'b00, rd, er);
    tl_xfer(OP_GET, 32'h008, 0, 2'b00, rd, er);
    n_cmp++;
    if ({rd, core_rst[0]} !== {32'd2, 1'b0}) begin
      n_fail++; $display("FAIL run_restart got st %0d rst %b want 2 0", rd, core_rst[0]);
    end
  endtask

  task automatic test_abort_done();
    logic [31:0] rd; logic er;
    tl_xfer(OP_PUT, 32'h000, 32'h2, 2'b01, rd, er);
    tl_xfer(OP_GET, 32'h008, 0, 2'b00, rd, er);
    n_cmp++;
    if ({rd, core_rst[0]} !== {32'd0, 1'b1}) begin
      n_fail++; $display("FAIL abort_state got st %0d rst %b want 0 1", rd, core_rst[0]);
    end
    tl_xfer(OP_GET, 32'h100, 0, 2'b00, rd, er);
    n_cmp++;
    if (rd !== 32'h0002_0000) begin
      n_fail++; $display("FAIL abort_irqst got %h want 00020000", rd);
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd; logic er; int n;
    tl_xfer(OP_PUT, 32'h000, 32'h1, 2'b00, rd, er);
    n = 0;
    while (core_rst[0] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (boot_addr[31:0] !== 32'h2000_0000) begin
      n_fail++; $display("FAIL race_boot got %h want 20000000", boot_addr[31:0]);
    end
    tl_xfer(OP_PUT, 32'h100, 32'h1, 2'b01, rd, er);
    tl_xfer(OP_GET, 32'h100, 0, 2'b00, rd, er);
    n_cmp++;
    if ({rd, irq} !== {32'h0002_0001, 1'b1}) begin
      n_fail++; $display("FAIL race_irqst got %h irq %b want 00020001 1", rd, irq);
    end
  endtask

  task automatic test_bus_errors();
    logic [31:0] rd; logic er;
    tl_xfer(OP_GET, 32'h0FC, 0, 2'b00, rd, er);
    n_cmp++;
    if ({er, rd} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL err_unmapped got err %b data %h want 1 0", er, rd);
    end
    tl_xfer(OP_PART, 32'h104, 32'h0, 2'b00, rd, er);
    n_cmp++;
    if (er !== 1'b1) begin
      n_fail++; $display("FAIL err_partial got %b want 1", er);
    end
    tl_xfer(OP_PUT, 32'h008, 32'h0, 2'b00, rd, er);
    n_cmp++;
    if (er !== 1'b1) begin
      n_fail++; $display("FAIL err_status_wr got %b want 1", er);
    end
    tl_xfer(OP_GET, 32'h104, 0, 2'b00, rd, er);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'h1}) begin
      n_fail++; $display("FAIL err_nochange got err %b data %h want 0 1", er, rd);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    tl_h2d.a_valid   = 1'b1;
    tl_h2d.a_opcode  = OP_GET;
    tl_h2d.a_size    = 2'd2;
    tl_h2d.a_source  = 8'h5A;
    tl_h2d.a_address = 32'h004;
    tl_h2d.d_ready   = 1'b0;
    @(posedge clk); #1;
    tl_h2d.a_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (tl_d2h.d_valid !== 1'b1 || tl_d2h.a_ready !== 1'b0 ||
          tl_d2h.d_data !== 32'h2000_0000 ||
          tl_d2h.d_source !== 8'h5A || tl_d2h.d_opcode !== 3'h1) begin
        n_fail++;
        $display("FAIL stall_%0d got v%b r%b d%h s%h o%h want v1 r0 d20000000 s5a o1",
                 i, tl_d2h.d_valid, tl_d2h.a_ready, tl_d2h.d_data,
                 tl_d2h.d_source, tl_d2h.d_opcode);
      end
      @(posedge clk); #1;
    end
    tl_h2d.d_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({tl_d2h.d_valid, tl_d2h.a_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_release got v/r=%b want 01",
               {tl_d2h.d_valid, tl_d2h.a_ready});
    end
  endtask

  task automatic test_midop_reset();
    logic [31:0] rd; logic er;
    @(negedge clk);
    tl_h2d.a_valid   = 1'b1;
    tl_h2d.a_opcode  = OP_GET;
    tl_h2d.a_address = 32'h008;
    tl_h2d.d_ready   = 1'b0;
    @(posedge clk); #1;
    tl_h2d.a_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    tl_h2d.d_ready = 1'b1;
    n_cmp++;
    if ({tl_d2h.d_valid, core_rst, irq} !== 4'b0110 ||
        boot_addr !== {DEF, DEF}) begin
      n_fail++;
      $display("FAIL midrst got v%b rst%b irq%b boot%h want v0 rst11 irq0 boot%h",
               tl_d2h.d_valid, core_rst, irq, boot_addr, {DEF, DEF});
    end
    tl_xfer(OP_GET, 32'h008, 0, 2'b00, rd, er);
    n_cmp++;
    if (rd !== 32'd0) begin
      n_fail++; $display("FAIL midrst_status got %0d want 0", rd);
    end
  endtask

  initial begin
    tl_h2d    = '0;
    core_done = 2'b00;
    test_reset();
    test_bringup();
    test_done_irq();
    test_watchdog();
    test_run_writes();
    test_abort_done();
    test_w1c_race();
    test_bus_errors();
    test_backpressure();
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicore_ctrl.md
Name: multicore_ctrl

Overview:
- Parametrised run-controller for NumCores worker cores (Vicuna cluster) in the multicore system.
- TL-UL device on the main crossbar, driven by the management core.
- Per core: boot address, held reset, start/abort, completion and watchdog timeout tracking.
- Raises one combined interrupt to the management core. Replaces the fixed two-core tie-offs.

Parameters:
NumCores, 2, number of controlled cores, 1..16
ResetCycles, 8, cycles core reset is held after start, >=1
TimeoutWidth, 32, width of per-core watchdog counter
DefaultBootAddr, 32'h0, reset value of BOOT_ADDR registers

Ports:
clk_sys_i  in  1  system clock
rst_sys_i  in  1  reset; one clock; reset is synchronous and active-high
tl_i  in  tlul_pkg::tl_h2d_t  register-access request from crossbar
tl_o  out  tlul_pkg::tl_d2h_t  register-access response
core_done_i  in  NumCores  per-core completion pulse (software-driven GPIO/CSR of worker)
core_rst_o  out  NumCores  per-core reset, active-high; inverted at core instantiation
boot_addr_o  out  32*NumCores  per-core boot address, core i at bits [32i+31:32i]
irq_o  out  1  level interrupt to management core

Behaviour:
- Register map (byte offsets, 32-bit, word-aligned):
  - 0x10*i+0x0 CTRL: write-only; bit0 START, bit1 ABORT; reads 0.
  - 0x10*i+0x4 BOOT_ADDR: R/W.
  - 0x10*i+0x8 STATUS: RO; [2:0] state code.
  - 0x10*i+0xC TIMEOUT: R/W; 0 disables watchdog.
  - 0x100 IRQ_STATUS: W1C; bit i = done core i, bit 16+i = timeout core i.
  - 0x104 IRQ_ENABLE: R/W, same bit layout.
- Reset values:
  - All cores IDLE; core_rst_o all 1; boot_addr_o = DefaultBootAddr.
  - IRQ_STATUS 0, IRQ_ENABLE 0, TIMEOUT 0; irq_o 0.
  - a_ready 1, d_valid 0.
- TL-UL handshake:
  - a_ready = !rsp_pending. Accept on a_valid & a_ready. Response d_valid the next cycle, held stable until d_ready.
  - d_source and d_size echo the request. Get -> AccessAckData; PutFullData -> AccessAck.
  - Other opcodes, unmapped offset, or write to STATUS -> d_error=1, no state change, rdata 0.
  - Accepted write takes effect in the acceptance cycle.
- Per-core FSM, state codes IDLE=0, RESET=1, RUN=2, DONE=3, TIMEOUT=4:
  - IDLE/DONE/TIMEOUT + START -> RESET. Latch BOOT_ADDR into boot_addr_o. Load reset counter with ResetCycles.
  - RESET: core_rst_o=1. Counter decrements; at 0 -> RUN. core_rst_o is high exactly ResetCycles cycles after the START write.
  - RUN: core_rst_o=0. Watchdog counts up from 0 each cycle.
    - core_done_i -> DONE and set done bit.
    - TIMEOUT!=0 and count reaches TIMEOUT-1 -> TIMEOUT and set timeout bit.
  - DONE/TIMEOUT: core_rst_o=1.
  - ABORT in RESET or RUN -> IDLE, core_rst_o=1, no IRQ bit.
  - START in RESET/RUN: ignored. ABORT in IDLE/DONE/TIMEOUT: ignored. START and ABORT both set: ABORT wins.
  - core_done_i outside RUN: ignored.
- Simultaneous events:
  - done and timeout in the same cycle -> DONE.
  - ABORT write and done in the same cycle -> IDLE, no IRQ.
  - W1C clear and hardware set of the same bit in the same cycle -> bit stays set.
- BOOT_ADDR writes during RUN update the register only; boot_addr_o changes only on START.
- irq_o = |(IRQ_STATUS & IRQ_ENABLE), registered; 1 cycle after the status or enable change.
- Watchdog saturates at all-ones; does not wrap.
- rst_sys_i mid-operation: every core returns to IDLE with reset asserted; a pending TL response is dropped.

Decomposition:
- multicore_ctrl_pkg:
  - core_state_e (3-bit enum).
  - Register offset constants: CTRL, BOOT_ADDR, STATUS, TIMEOUT, IRQ_STATUS, IRQ_ENABLE.
  - IrqTimeoutBitOffset=16, MaxCores=16.
- Sub-module multicore_ctrl_core_fsm:
  - One per core, generate loop.
  - Holds state, reset counter, watchdog, boot-address latch.
  - Emits done/timeout set pulses.
- Top level: TL-UL decode, IRQ registers.

Test Plan:
- Reset, then read STATUS0 and IRQ_STATUS -> 0 and 0; core_rst_o=2'b11; boot_addr_o = DefaultBootAddr for both cores.
- Core 0 bring-up:
  - Stimulus: write BOOT_ADDR0=0x0010_0000, then CTRL0=1.
  - Response: core_rst_o[0] high 8 cycles then low; STATUS0 reads 1, then 2; boot_addr_o[31:0]=0x0010_0000.
- Completion IRQ:
  - Stimulus: IRQ_ENABLE=0x1; pulse core_done_i[0] in RUN.
  - Response: STATUS0=3; irq_o=1 one cycle later. W1C 0x1 to IRQ_STATUS -> irq_o=0.
- Watchdog:
  - Stimulus: TIMEOUT1=100, start core 1, no done.
  - Response: STATUS1=4 exactly 100 cycles after entering RUN; IRQ_STATUS bit 17 set; core_rst_o[1]=1.
- Edge cases:
  - ABORT in RUN and core_done_i in the same cycle -> IDLE, IRQ_STATUS unchanged.
  - START during RUN -> ignored.
- Bus errors:
  - Get to 0x0FC, and PutPartialData -> d_error=1.
  - d_ready held low 5 cycles -> d_valid and data stable, a_ready=0 throughout.
